// File: rtl/add_reg_mul_i8_i8_i8_b_i8.sv
`default_nettype none
// ============================================================================
// Module  : add_reg_mul_i8_i8_i8_b_i8
// Brief   : y = R + c, where R captures the low byte of a*b when en is high.
//           All operands are signed 8-bit and the result wraps modulo 256.
// Revision: 1.0 - initial release
// ============================================================================
module add_reg_mul_i8_i8_i8_b_i8 (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [7:0] c,
    input  logic       en,
    output logic [7:0] y
);

    logic [7:0] product_low;
    logic [7:0] product_reg = 8'd0;

    // The low byte of a two's-complement product is the same whether the
    // operands are treated as signed or unsigned, so the upper byte is never built.
    assign product_low = a * b;

    always_ff @(posedge clock) begin
        if (reset) begin
            product_reg <= 8'd0;
        end else if (en) begin
            product_reg <= product_low;
        end
    end

    assign y = product_reg + c;

endmodule
`default_nettype wire

// File: tb/tb_add_reg_mul_i8_i8_i8_b_i8.sv
`default_nettype none
// ============================================================================
// Module  : tb_add_reg_mul_i8_i8_i8_b_i8
// Brief   : Scenario bench for the registered multiply-add primitive.
// Revision: 1.0 - initial release
// ============================================================================
module tb_add_reg_mul_i8_i8_i8_b_i8;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic       en;
    logic [7:0] y;

    int total = 0;
    int bad   = 0;

    logic [7:0] sb_q[$];

    add_reg_mul_i8_i8_i8_b_i8 dut (
        .clock (clock),
        .reset (reset),
        .a     (a),
        .b     (b),
        .c     (c),
        .en    (en),
        .y     (y)
    );

    always #5 clock = ~clock;

    // Inputs change 2 time units after the rising edge; outputs are read at +3.
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    function automatic logic [7:0] low_product(input logic [7:0] x, input logic [7:0] z);
        logic signed [15:0] full;
        full = $signed(x) * $signed(z);
        return full[7:0];
    endfunction

    task automatic load_expect(input logic [7:0] x, input logic [7:0] z);
        a  = x;
        b  = z;
        en = 1'b1;
        sb_q.push_back(low_product(x, z));
    endtask

    task automatic check_pop(input string name);
        logic [7:0] r;
        logic [7:0] exp;
        #1;
        total++;
        if (sb_q.size() == 0) begin
            bad++;
            $display("FAIL %s: scoreboard empty, y=%0h", name, y);
        end else begin
            r   = sb_q.pop_front();
            exp = r + c;
            if (y !== exp) begin
                bad++;
                $display("FAIL %s: y=%0h expected %0h", name, y, exp);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; a = 8'd4; b = 8'd2; c = 8'd3; en = 1'b1;
        #1;
        total++;
        if (y !== 8'd3) begin bad++; $display("FAIL powerup: y=%0h expected 03", y); end
        tick();
        #1;
        total++;
        if (y !== 8'd3) begin bad++; $display("FAIL reset_hold: y=%0h expected 03", y); end
        reset = 1'b0;
        #1;
        total++;
        if (y !== 8'd3) begin bad++; $display("FAIL reset_release: y=%0h expected 03", y); end
        tick();
        a = 8'd0; b = 8'd0; en = 1'b0;
        #1;
        total++;
        if (y !== 8'd11) begin bad++; $display("FAIL first_load: y=%0h expected 0b", y); end
    endtask

    task automatic test_hold();
        logic [7:0] exp;
        c = 8'd0;
        a = 8'd5; b = 8'd3; en = 1'b1;
        tick();
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            c = (i < 5) ? 8'd0 : 8'($urandom);
            exp = 8'd15 + c;
            #1;
            total++;
            if (y !== exp) begin bad++; $display("FAIL hold[%0d]: y=%0h expected %0h", i, y, exp); end
            tick();
        end
    endtask

    task automatic test_comb_c();
        logic [7:0] cv[3];
        logic [7:0] ev[3];
        cv[0] = 8'd0; cv[1] = 8'd1; cv[2] = 8'hFF;
        ev[0] = 8'd15; ev[1] = 8'd16; ev[2] = 8'd14;
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            c = cv[i];
            #1;
            total++;
            if (y !== ev[i]) begin bad++; $display("FAIL comb_c[%0d]: y=%0h expected %0h", i, y, ev[i]); end
            tick();
        end
    endtask

    task automatic test_signed_wrap();
        c = 8'd0;
        load_expect(8'hFD, 8'd7);
        tick();
        en = 1'b0;
        check_pop("signed_mul");
        total++;
        if (y !== 8'hEB) begin bad++; $display("FAIL signed_const: y=%0h expected eb", y); end
        load_expect(8'd16, 8'd16);
        tick();
        en = 1'b0;
        check_pop("wrap_256");
        total++;
        if (y !== 8'h00) begin bad++; $display("FAIL wrap_const: y=%0h expected 00", y); end
        load_expect(8'd127, 8'd1);
        tick();
        en = 1'b0;
        c = 8'd1;
        check_pop("sum_wrap");
        total++;
        if (y !== 8'h80) begin bad++; $display("FAIL sum_wrap_const: y=%0h expected 80", y); end
        load_expect(8'h80, 8'hFF);
        tick();
        en = 1'b0;
        c = 8'h7F;
        check_pop("neg_by_neg");
    endtask

    task automatic test_reset_priority();
        c = 8'd0;
        a = 8'd4; b = 8'd2; en = 1'b1;
        tick();
        en = 1'b0;
        #1;
        total++;
        if (y !== 8'd8) begin bad++; $display("FAIL prio_setup: y=%0h expected 08", y); end
        reset = 1'b1; en = 1'b1; a = 8'd9; b = 8'd9; c = 8'd5;
        tick();
        reset = 1'b0; en = 1'b0;
        #1;
        total++;
        if (y !== 8'd5) begin bad++; $display("FAIL reset_priority: y=%0h expected 05", y); end
        tick();
        #1;
        total++;
        if (y !== 8'd5) begin bad++; $display("FAIL reset_stays: y=%0h expected 05", y); end
    endtask

    task automatic test_back_to_back();
        c = 8'd0;
        load_expect(8'd1, 8'd2);
        for (int i = 2; i <= 6; i++) begin
            tick();
            if (i <= 5) load_expect(8'(i), 8'd2);
            else en = 1'b0;
            check_pop($sformatf("b2b[%0d]", i - 1));
        end
        total++;
        if (y !== 8'd10) begin bad++; $display("FAIL b2b_last: y=%0h expected 0a", y); end
    endtask

    initial begin
        test_reset();
        test_hold();
        test_comb_c();
        test_signed_wrap();
        test_reset_priority();
        test_back_to_back();
        total++;
        if (sb_q.size() != 0) begin bad++; $display("FAIL scoreboard_drain: left=%0d expected 0", sb_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
